pt5_result_packer: RTL
======================

Name: pt5_result_packer

Overview:
Write-side counterpart of the PT-5 unpack path. It accepts a serial stream of 2-bit trits and packs 5 trits per byte (base-3 PT-5 code) and 3 bytes per 24-bit word. Each completed word is written into one port of the dual-bank ternary SRAM at base_addr, base_addr+1, and so on. It sits between the vector-engine result quantiser and the SRAM write port, and is started and reported to the AXI control plane like the frame controller.

Parameters:
ADDR_WIDTH, 12, SRAM word address width; addresses wrap modulo 2^ADDR_WIDTH.
WORD_WIDTH, 24, SRAM word width; fixed at 3 bytes, and any other value is a elaboration error.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; latches base_addr and begins a packing run; ignored unless IDLE.
base_addr  in  ADDR_WIDTH  first SRAM word address of the run.
s_trit  in  2  input trit: 00=0, 01=+1, 10=-1, 11=invalid.
s_valid  in  1  s_trit valid.
s_last  in  1  qualifies the final trit of the run.
s_ready  out  1  packer accepts a trit this cycle when s_valid&s_ready.
mem_addr  out  ADDR_WIDTH  SRAM write address.
mem_din  out  WORD_WIDTH  packed word; byte k in bits [8k+7:8k].
mem_we  out  1  write strobe; held until mem_ready.
mem_ready  in  1  SRAM accepts the write this cycle when mem_we&mem_ready.
busy  out  1  high from start accepted until done.
done  out  1  one-cycle pulse after the final word write completes.
words_written  out  ADDR_WIDTH+1  number of words written in the current or last run.
err_invalid  out  1  sticky; set on any accepted 2'b11 trit; cleared by start or reset.

Behaviour:
- Reset: all outputs 0, state IDLE, accumulators cleared. Reset wins over every other event. Reset during WRITE drops mem_we in the next cycle and no done pulse is produced.
- Digit mapping: d = t+1, so -1→0, 0→1, +1→2. An invalid trit maps to d=1 (encoded as zero) and sets err_invalid.
- Byte code: trit j (0..4, first-received = j=0) contributes d·3^j. The byte value is 0..242. Compute it with a running sum and a 3^j weight register; do not use a multiplier.
- Word assembly: byte k (0..2) is filled in arrival order; byte 0 occupies the LSBs.
- FSM states:
  - IDLE: s_ready=0. start → ACCEPT; clear counters, err_invalid and words_written; addr ← base_addr.
  - ACCEPT: s_ready=1. Each handshake adds the trit to the accumulator.
    - When the 15th trit of the word is accepted, or any trit with s_last=1, go to WRITE in the next cycle. mem_we=1 and mem_din is valid in that cycle, i.e. 1-cycle latency from the final handshake.
  - WRITE: s_ready=0. mem_addr and mem_din are held stable while mem_we=1 and mem_ready=0.
    - On mem_we&mem_ready: words_written++. If the word was last, go to DONE; otherwise go to ACCEPT with addr ← addr+1 (wraps to 0).
  - DONE: done=1 for one cycle, busy=0 next cycle → IDLE.
- Partial flush on s_last:
  - Unfilled trit positions of the current byte are padded with d=1.
  - Unfilled bytes are set to PAD_BYTE=0x79, which is five encoded zeros.
  - s_last on the 15th trit produces exactly one word with no extra pad word.
- s_valid while not ACCEPT: ignored, with no state change. start while busy: ignored.

Decomposition:
- Package pt5_pkg:
  - trit encodings TRIT_ZERO/TRIT_POS/TRIT_NEG/TRIT_INV
  - TRITS_PER_BYTE=5, BYTES_PER_WORD=3, TRITS_PER_WORD=15
  - POW3 table {1,3,9,27,81}
  - PAD_BYTE=8'h79
  - FSM state typedef
- The unpackers also import this package.
- Sub-module pt5_byte_accumulator holds the trit-index counter, the weight register and the running sum. Its interface is clear / add-trit / byte_full / byte_value. The top level owns the FSM, byte slotting, address and the SRAM handshake.

Test Plan:
- start base=0x010; 15 trits +1, last on the 15th, mem_ready=1 → one write, addr 0x010, din 0xF2F2F2, words_written=1, done pulse 2 cycles after the last handshake.
- 30 trits -1, last on the 30th → writes 0x000000 at 0x010 then 0x011; words_written=2.
- Single +1 trit with s_last → din 0x79797A (byte0 = 2+3+9+27+81 = 122).
- mem_ready held low 4 cycles during WRITE → mem_we, mem_addr and mem_din stable, s_ready=0; the write completes on the 5th cycle.
- Run with base=0xFFF spanning 2 words → second write at 0x000. A 2'b11 trit in the stream encodes as 0 and sets err_invalid; the next start clears it.
- reset asserted mid-WRITE → next cycle all outputs 0, no done; a subsequent start runs normally. start issued while busy → no effect.

Source files
------------

// File: rtl/pt5_pkg.sv
// Purpose: shared PT-5 trit encodings, packing geometry and FSM state type for the pack/unpack paths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pt5_pkg;

    // Trit wire encodings
    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_NEG  = 2'b10;
    localparam logic [1:0] TRIT_INV  = 2'b11;

    // Packing geometry
    localparam int TRITS_PER_BYTE = 5;
    localparam int BYTES_PER_WORD = 3;
    localparam int TRITS_PER_WORD = TRITS_PER_BYTE * BYTES_PER_WORD;

    // Positional weights of the base-3 byte code
    localparam logic [7:0] POW3 [TRITS_PER_BYTE] = '{8'd1, 8'd3, 8'd9, 8'd27, 8'd81};

    // Five encoded zeros (d=1 in every position): 1+3+9+27+81
    localparam logic [7:0] PAD_BYTE = 8'h79;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } pt5_state_e;

endpackage

// File: rtl/pt5_byte_accumulator.sv
// Purpose: accumulates up to five trits into one PT-5 byte using a running sum and a 3^j weight register.
// Latency: byte_value is combinational and already includes the trit presented with add.
// Backpressure: none; the caller only asserts add on an accepted trit.
//
// Ports: clear  - restart an empty byte (priority over add)
//        add    - accept trit this cycle
//        trit   - 2-bit trit encoding
//        byte_full  - the trit being added is the fifth of the byte
//        byte_value - byte code including the trit being added, unfilled positions padded
module pt5_byte_accumulator
    import pt5_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       add,
    input  logic [1:0] trit,
    output logic       byte_full,
    output logic [7:0] byte_value
);

    logic [2:0] trit_idx;
    logic [7:0] weight;
    logic [7:0] sum;
    logic [7:0] sum_nxt;

    // The sum starts at the all-padding value (every position d=1), so each
    // trit only adjusts its own position by (d-1)*3^j. A partially filled
    // byte therefore always reads back correctly padded, and an untouched
    // byte equals PAD_BYTE.
    always_comb begin
        sum_nxt = sum;
        case (trit)
            TRIT_POS:           sum_nxt = sum + weight;
            TRIT_NEG:           sum_nxt = sum - weight;
            TRIT_ZERO, TRIT_INV: sum_nxt = sum;
            default:            sum_nxt = sum;
        endcase
    end

    assign byte_full  = add && (trit_idx == 3'(TRITS_PER_BYTE - 1));
    assign byte_value = add ? sum_nxt : sum;

    always_ff @(posedge clk) begin
        if (reset || clear || byte_full) begin
            trit_idx <= '0;
            weight   <= POW3[0];
            sum      <= PAD_BYTE;
        end else if (add) begin
            trit_idx <= trit_idx + 3'd1;
            weight   <= weight + {weight[6:0], 1'b0};
            sum      <= sum_nxt;
        end
    end

endmodule

// File: rtl/pt5_result_packer.sv
// Purpose: packs a serial trit stream into PT-5 bytes, three bytes per word, and writes words to SRAM from base_addr upward.
// Latency: mem_we rises the cycle after the handshake that completes a word or carries s_last; done one cycle after the final write.
// Backpressure: s_ready is low outside ACCEPT; mem_we, mem_addr and mem_din hold until mem_ready.
//
// Ports: start/base_addr - begin a run at base_addr (IDLE only)
//        s_trit/s_valid/s_last/s_ready - trit stream
//        mem_addr/mem_din/mem_we/mem_ready - SRAM write port
//        busy/done/words_written/err_invalid - run status
module pt5_result_packer
    import pt5_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [1:0]            s_trit,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_din,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic                  err_invalid
);

    if (WORD_WIDTH != 8 * BYTES_PER_WORD) begin : g_bad_word_width
        $error("pt5_result_packer: WORD_WIDTH must be 24");
    end

    localparam logic [WORD_WIDTH-1:0] PAD_WORD = {BYTES_PER_WORD{PAD_BYTE}};

    pt5_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0] word_q;
    logic [1:0]            byte_idx_q;
    logic                  last_q;
    logic [ADDR_WIDTH:0]   words_q;
    logic                  err_q;

    logic       start_ok;
    logic       hs;
    logic       acc_clear;
    logic       acc_full;
    logic [7:0] acc_value;
    logic       word_end;
    logic       wr_fire;

    assign start_ok = (state_q == ST_IDLE) && start;
    assign hs       = (state_q == ST_ACCEPT) && s_valid;
    assign wr_fire  = (state_q == ST_WRITE) && mem_ready;
    // A word closes on the fifth trit of its third byte, or early on s_last.
    assign word_end = hs && (s_last || (acc_full && (byte_idx_q == 2'(BYTES_PER_WORD - 1))));
    // After s_last the byte is flushed, so the next run must start empty.
    assign acc_clear = start_ok || (hs && s_last);

    pt5_byte_accumulator u_acc (
        .clk        (clk),
        .reset      (reset),
        .clear      (acc_clear),
        .add        (hs),
        .trit       (s_trit),
        .byte_full  (acc_full),
        .byte_value (acc_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        mem_we  = 1'b0;
        done    = 1'b0;
        busy    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_d = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                s_ready = 1'b1;
                if (word_end) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                mem_we = 1'b1;
                if (mem_ready) state_d = last_q ? ST_DONE : ST_ACCEPT;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            last_q     <= 1'b0;
            words_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (start_ok) begin
                addr_q     <= base_addr;
                word_q     <= PAD_WORD;
                byte_idx_q <= '0;
                last_q     <= 1'b0;
                words_q    <= '0;
                err_q      <= 1'b0;
            end
            if (hs) begin
                if (s_trit == TRIT_INV) err_q <= 1'b1;
                // Slot the byte when it is complete or flushed by s_last;
                // untouched slots keep PAD_BYTE from the word preset.
                if (acc_full || s_last) begin
                    word_q[{byte_idx_q, 3'b000} +: 8] <= acc_value;
                    byte_idx_q <= byte_idx_q + 2'd1;
                end
                if (word_end) last_q <= s_last;
            end
            if (wr_fire) begin
                words_q <= words_q + 1'b1;
                if (!last_q) begin
                    addr_q     <= addr_q + 1'b1;
                    word_q     <= PAD_WORD;
                    byte_idx_q <= '0;
                end
            end
        end
    end

    assign mem_addr      = addr_q;
    assign mem_din       = word_q;
    assign words_written = words_q;
    assign err_invalid   = err_q;

endmodule
